// File: rtl/imm_decode_stage.sv
// Immediate-decode stage: decodes RV32I/RV64I immediates from raw instruction
// words and queues {imm, fmt, illegal} results in a 2-entry output FIFO.
// A saturating counter tracks accepted illegal words.
module imm_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    input  logic             flush,
    input  logic             ill_clr,
    output logic [CNT_W-1:0] ill_count
);

    localparam logic [2:0] FmtR   = 3'd0;
    localparam logic [2:0] FmtI   = 3'd1;
    localparam logic [2:0] FmtS   = 3'd2;
    localparam logic [2:0] FmtB   = 3'd3;
    localparam logic [2:0] FmtU   = 3'd4;
    localparam logic [2:0] FmtJ   = 3'd5;
    localparam logic [2:0] FmtZ   = 3'd6;
    localparam logic [2:0] FmtIll = 3'd7;

    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpOp     = 7'b0110011;

    // Slot 0 is always the head; slot 1 only holds the second entry.
    logic [XLEN-1:0]  r_imm0, r_imm1;
    logic [2:0]       r_fmt0, r_fmt1;
    logic             r_ill0, r_ill1;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_ill_cnt;

    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;
    logic             w_ill;
    logic             w_push;
    logic             w_pop;
    logic             w_unused_funct3;

    assign w_unused_funct3 = ^in_instr[13:12];

    assign in_ready  = !flush && (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    // A pop coinciding with flush is void; the flush empties the buffer anyway.
    assign w_pop     = out_valid && out_ready && !flush;

    assign out_imm     = r_imm0;
    assign out_fmt     = r_fmt0;
    assign out_illegal = r_ill0;
    assign ill_count   = r_ill_cnt;

    // Decode the incoming word's immediate and format.
    always_comb begin
        w_imm = '0;
        w_fmt = FmtIll;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:0])
                OpImm, OpLoad, OpJalr: begin
                    w_fmt = FmtI;
                    w_imm = XLEN'($signed(in_instr[31:20]));
                end
                OpSystem: begin
                    if (in_instr[14]) begin
                        w_fmt = FmtZ;
                        w_imm = XLEN'(in_instr[19:15]);
                    end else begin
                        w_fmt = FmtI;
                        w_imm = XLEN'($signed(in_instr[31:20]));
                    end
                end
                OpStore: begin
                    w_fmt = FmtS;
                    w_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
                end
                OpBranch: begin
                    w_fmt = FmtB;
                    w_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                           in_instr[11:8], 1'b0}));
                end
                OpJal: begin
                    w_fmt = FmtJ;
                    w_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                           in_instr[30:21], 1'b0}));
                end
                OpLui, OpAuipc: begin
                    w_fmt = FmtU;
                    w_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
                end
                OpOp: begin
                    w_fmt = FmtR;
                    w_imm = '0;
                end
                default: begin
                    w_fmt = FmtIll;
                    w_imm = '0;
                end
            endcase
        end
    end

    assign w_ill = (w_fmt == FmtIll);

    // Output FIFO: occupancy and entry storage; stale head data is kept when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_imm0  <= '0;
            r_fmt0  <= 3'd0;
            r_ill0  <= 1'b0;
            r_imm1  <= '0;
            r_fmt1  <= 3'd0;
            r_ill1  <= 1'b0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_imm0  <= w_imm;
                        r_fmt0  <= w_fmt;
                        r_ill0  <= w_ill;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_imm0 <= w_imm;
                        r_fmt0 <= w_fmt;
                        r_ill0 <= w_ill;
                    end else if (w_push) begin
                        r_imm1  <= w_imm;
                        r_fmt1  <= w_fmt;
                        r_ill1  <= w_ill;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only a pop can happen.
                    if (w_pop) begin
                        r_imm0  <= r_imm1;
                        r_fmt0  <= r_fmt1;
                        r_ill0  <= r_ill1;
                        r_count <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Saturating illegal-word counter; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ill_cnt <= '0;
        end else if (ill_clr) begin
            r_ill_cnt <= '0;
        end else if (w_push && w_ill && (r_ill_cnt != {CNT_W{1'b1}})) begin
            r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: one XLEN=32/CNT_W=2 instance and one
// XLEN=64 instance share stimulus; expected values are hand-computed.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;
    logic        flush;
    logic        ill_clr;

    logic        rdy32, val32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [1:0]  cnt32;

    logic        rdy64, val64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [7:0]  cnt64;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .CNT_W(2)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
        .out_valid(val32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .flush(flush), .ill_clr(ill_clr), .ill_count(cnt32)
    );

    imm_decode_stage #(.XLEN(64), .CNT_W(8)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
        .out_valid(val64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .flush(flush), .ill_clr(ill_clr), .ill_count(cnt64)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for one cycle and check the head afterwards (out_ready held high).
    task automatic issue32(input string tag, input logic [31:0] instr,
                           input logic [31:0] exp_imm, input logic [2:0] exp_fmt);
        in_valid = 1'b1;
        in_instr = instr;
        step();
        in_valid = 1'b0;
        check_eq({tag, ".valid"}, 64'(val32), 64'd1);
        check_eq({tag, ".imm"}, 64'(imm32), 64'(exp_imm));
        check_eq({tag, ".fmt"}, 64'(fmt32), 64'(exp_fmt));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b1;
        flush     = 1'b0;
        ill_clr   = 1'b0;
        step();
        step();
        check_eq("rst.valid", 64'(val32), 64'd0);
        check_eq("rst.ready", 64'(rdy32), 64'd1);
        check_eq("rst.imm", 64'(imm32), 64'd0);
        check_eq("rst.fmt", 64'(fmt32), 64'd0);
        check_eq("rst.ill", 64'(ill32), 64'd0);
        check_eq("rst.cnt", 64'(cnt32), 64'd0);
        rst = 1'b0;
        step();

        // Back-to-back accepts with out_ready high.
        in_valid = 1'b1;
        in_instr = 32'hFFF00093;
        step();
        check_eq("addi.valid", 64'(val32), 64'd1);
        check_eq("addi.imm", 64'(imm32), 64'hFFFFFFFF);
        check_eq("addi.fmt", 64'(fmt32), 64'd1);
        check_eq("addi.ready", 64'(rdy32), 64'd1);
        in_instr = 32'hFE112E23;
        step();
        in_valid = 1'b0;
        check_eq("sw.imm", 64'(imm32), 64'hFFFFFFFC);
        check_eq("sw.fmt", 64'(fmt32), 64'd2);

        issue32("beq", 32'hFE000CE3, 32'hFFFFFFF8, 3'd3);
        issue32("jal", 32'h0010006F, 32'h00000800, 3'd5);
        issue32("csrrwi", 32'h300FD073, 32'h0000001F, 3'd6);
        issue32("csrrw", 32'h34011073, 32'h00000340, 3'd1);
        issue32("lw", 32'h00452083, 32'h00000004, 3'd1);
        issue32("jalr", 32'h008080E7, 32'h00000008, 3'd1);
        issue32("add", 32'h00B50533, 32'h00000000, 3'd0);
        check_eq("add.ill", 64'(ill32), 64'd0);

        // U-type on both widths.
        issue32("lui32", 32'h123452B7, 32'h12345000, 3'd4);
        check_eq("lui64.imm", imm64, 64'h0000000012345000);
        check_eq("lui64.fmt", 64'(fmt64), 64'd4);
        issue32("luineg32", 32'h800002B7, 32'h80000000, 3'd4);
        check_eq("luineg64.imm", imm64, 64'hFFFFFFFF80000000);
        check_eq("luineg64.fmt", 64'(fmt64), 64'd4);
        issue32("auipc32", 32'hFFFFF297, 32'hFFFFF000, 3'd4);
        check_eq("auipc64.imm", imm64, 64'hFFFFFFFFFFFFF000);

        // Drain, then backpressure with three offered words.
        step();
        check_eq("drain.valid", 64'(val32), 64'd0);
        check_eq("empty.hold", 64'(imm32), 64'hFFFFF000);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        step();
        check_eq("bp.w1.imm", 64'(imm32), 64'd1);
        check_eq("bp.w1.ready", 64'(rdy32), 64'd1);
        in_instr = 32'h00200093;
        step();
        check_eq("bp.full.ready", 64'(rdy32), 64'd0);
        check_eq("bp.full.head", 64'(imm32), 64'd1);
        in_instr = 32'h00300093;
        step();
        check_eq("bp.stall.ready", 64'(rdy32), 64'd0);
        check_eq("bp.stall.head", 64'(imm32), 64'd1);
        check_eq("bp.stall.valid", 64'(val32), 64'd1);
        out_ready = 1'b1;
        step();
        check_eq("bp.pop1.head", 64'(imm32), 64'd2);
        check_eq("bp.pop1.ready", 64'(rdy32), 64'd1);
        step();
        in_valid = 1'b0;
        check_eq("bp.pop2.head", 64'(imm32), 64'd3);
        check_eq("bp.pop2.valid", 64'(val32), 64'd1);
        step();
        check_eq("bp.empty.valid", 64'(val32), 64'd0);
        check_eq("bp.empty.hold", 64'(imm32), 64'd3);

        // Saturating illegal counter (CNT_W=2 instance).
        in_valid = 1'b1;
        in_instr = 32'h0000007F;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("ill%0d.cnt", i), 64'(cnt32), (i < 3) ? 64'(i + 1) : 64'd3);
            check_eq($sformatf("ill%0d.fmt", i), 64'(fmt32), 64'd7);
            check_eq($sformatf("ill%0d.imm", i), 64'(imm32), 64'd0);
            check_eq($sformatf("ill%0d.flag", i), 64'(ill32), 64'd1);
        end
        ill_clr = 1'b1;
        step();
        ill_clr = 1'b0;
        check_eq("illclr.cnt", 64'(cnt32), 64'd0);
        in_instr = 32'h00000001;
        step();
        in_valid = 1'b0;
        check_eq("cmp.fmt", 64'(fmt32), 64'd7);
        check_eq("cmp.cnt", 64'(cnt32), 64'd1);

        // Flush with two entries held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00500093;
        step();
        step();
        in_valid = 1'b0;
        check_eq("fl.full.ready", 64'(rdy32), 64'd0);
        flush = 1'b1;
        #1;
        check_eq("fl.ready.during", 64'(rdy32), 64'd0);
        step();
        flush = 1'b0;
        check_eq("fl.valid", 64'(val32), 64'd0);
        check_eq("fl.cnt.kept", 64'(cnt32), 64'd1);
        #1;
        check_eq("fl.ready.after", 64'(rdy32), 64'd1);

        // Asynchronous reset with one entry held.
        in_valid = 1'b1;
        in_instr = 32'h00700093;
        step();
        in_valid = 1'b0;
        check_eq("ar.pre.valid", 64'(val32), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("ar.valid", 64'(val32), 64'd0);
        check_eq("ar.cnt", 64'(cnt32), 64'd0);
        check_eq("ar.imm", 64'(imm32), 64'd0);
        step();
        rst = 1'b0;
        step();
        check_eq("ar.ready", 64'(rdy32), 64'd1);
        check_eq("ar.valid.after", 64'(val32), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
